// File: rtl/adt7310_responder_pkg.sv
// Shared types and constants for the ADT7310 register-interface responder.
package adt7310_responder_pkg;

  // Transaction FSM: waiting for CS, receiving command, data phase, surplus bits.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Register map addresses (command byte bits 5:3).
  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_CONFIG = 3'd1;
  localparam logic [2:0] ADDR_TEMP   = 3'd2;
  localparam logic [2:0] ADDR_ID     = 3'd3;

  // Config bits 6:5 value selecting a single one-shot conversion.
  localparam logic [1:0] MODE_ONESHOT = 2'b01;

endpackage

// File: rtl/adt7310_responder_sync_edge.sv
// Input synchronizers for the SPI pins plus edge strobes on the synchronized
// SCK and CS. Strobes are one Clk cycle wide and aligned with the synchronized
// levels presented on cs_n_s / mosi_s.
module spi_slave_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  input  logic cs_n,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic cs_n_s,
  output logic mosi_s
);

  logic sck_m, sck_s, sck_d;
  logic cs_m, cs_s, cs_d;
  logic mosi_m;

  // Two-flop synchronizers plus one delay stage for edge detection. SCK and CS
  // reset to their idle-high levels so no edge is seen on reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_m  <= 1'b1;
      sck_s  <= 1'b1;
      sck_d  <= 1'b1;
      cs_m   <= 1'b1;
      cs_s   <= 1'b1;
      cs_d   <= 1'b1;
      mosi_m <= 1'b0;
      mosi_s <= 1'b0;
    end else begin
      sck_m  <= sck;
      sck_s  <= sck_m;
      sck_d  <= sck_s;
      cs_m   <= cs_n;
      cs_s   <= cs_m;
      cs_d   <= cs_s;
      mosi_m <= mosi;
      mosi_s <= mosi_m;
    end
  end

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_n_s   = cs_s;

endmodule

// File: rtl/adt7310_responder.sv
// ADT7310 SPI register-interface responder (mode 3, SCK oversampled on Clk_i).
// Optional macro ADT7310_RESPONDER_CONVDELAY_EN: when defined, a one-shot
// conversion takes ConvCycles_g cycles and Busy_o is driven; otherwise the
// temperature register updates the cycle after the one-shot pulse.
module adt7310_responder
  import adt7310_responder_pkg::*;
#(
  parameter int          ConvCycles_g = 240,
  parameter logic [7:0]  IdValue_g    = 8'hC3
) (
  input  logic        Clk_i,
  input  logic        Reset_n_i,
  input  logic        SCK_i,
  input  logic        CS_n_i,
  input  logic        MOSI_i,
  output logic        MISO_o,
  input  logic [15:0] Temperature_i,
  output logic [7:0]  ConfigReg_o,
  output logic [15:0] TempReg_o,
  output logic        OneShot_o,
  output logic        Busy_o
);

  logic sck_rise, sck_fall, cs_fall, cs_rise, cs_n_s, mosi_s;

  spi_slave_sync_edge u_sync (
    .clk      (Clk_i),
    .rst_n    (Reset_n_i),
    .sck      (SCK_i),
    .cs_n     (CS_n_i),
    .mosi     (MOSI_i),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_fall  (cs_fall),
    .cs_rise  (cs_rise),
    .cs_n_s   (cs_n_s),
    .mosi_s   (mosi_s)
  );

  state_t      state_q;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  rx_q;
  logic [15:0] tx_q;
  logic        is_read_q;
  logic        len16_q;
  logic [2:0]  addr_q;
  logic        temp_rd_q;
  logic        miso_q;
  logic [7:0]  config_q;
  logic        oneshot_q;
  logic [15:0] temp_q;
  logic        rdy_n_q;

  logic [7:0]  rx_next;
  logic [15:0] rd_word;
  logic [3:0]  last_bit;
  logic        wr_commit;
  logic        trig;
  logic        rdy_clr;

  // Byte being completed by the current SCK rise: command during CMD,
  // config value during a write's data phase.
  assign rx_next  = {rx_q[6:0], mosi_s};
  assign last_bit = (is_read_q && len16_q) ? 4'd15 : 4'd7;

  // Config commit happens on the 8th data rise of a config write, never on
  // the same cycle CS is seen rising.
  assign wr_commit = (state_q == ST_DATA) && !is_read_q && (addr_q == ADDR_CONFIG)
                     && sck_rise && !cs_n_s && !cs_rise && (bit_cnt_q == 4'd7);
  assign trig      = wr_commit && (rx_next[6:5] == MODE_ONESHOT);

  // A temperature read re-arms RDY_n when its transaction closes.
  assign rdy_clr   = cs_rise && temp_rd_q;

  // Register contents snapshotted at command decode; 8-bit registers are
  // padded with 1s so MISO idles high once they are shifted out.
  always_comb begin
    rd_word = 16'hFFFF;
    case (rx_next[5:3])
      ADDR_STATUS: rd_word = {rdy_n_q, 7'b0, 8'hFF};
      ADDR_CONFIG: rd_word = {config_q, 8'hFF};
      ADDR_TEMP:   rd_word = temp_q;
      ADDR_ID:     rd_word = {IdValue_g, 8'hFF};
      default:     rd_word = {8'h00, 8'hFF};
    endcase
  end

  // Transaction FSM: command decode, read shifter, config write and MISO.
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 4'd0;
      rx_q      <= 8'h00;
      tx_q      <= 16'hFFFF;
      is_read_q <= 1'b0;
      len16_q   <= 1'b0;
      addr_q    <= 3'd0;
      temp_rd_q <= 1'b0;
      miso_q    <= 1'b1;
      config_q  <= 8'h00;
      oneshot_q <= 1'b0;
    end else begin
      oneshot_q <= trig;
      if (wr_commit) config_q <= rx_next;

      if (cs_rise) begin
        state_q   <= ST_IDLE;
        miso_q    <= 1'b1;
        temp_rd_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cs_fall) begin
              state_q   <= ST_CMD;
              bit_cnt_q <= 4'd0;
            end
          end
          ST_CMD: begin
            if (!cs_n_s && sck_rise) begin
              rx_q <= rx_next;
              if (bit_cnt_q == 4'd7) begin
                state_q   <= ST_DATA;
                bit_cnt_q <= 4'd0;
                is_read_q <= rx_next[6];
                addr_q    <= rx_next[5:3];
                len16_q   <= (rx_next[5:3] == ADDR_TEMP);
                temp_rd_q <= rx_next[6] && (rx_next[5:3] == ADDR_TEMP);
                tx_q      <= rd_word;
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          ST_DATA: begin
            if (!cs_n_s) begin
              if (sck_fall && is_read_q) begin
                miso_q <= tx_q[15];
                tx_q   <= {tx_q[14:0], 1'b1};
              end
              if (sck_rise) begin
                rx_q <= rx_next;
                if (bit_cnt_q == last_bit) begin
                  state_q <= ST_DONE;
                end else begin
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                end
              end
            end
          end
          ST_DONE: begin
            if (!cs_n_s && sck_fall) miso_q <= 1'b1;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef ADT7310_RESPONDER_CONVDELAY_EN
  localparam int CW = $clog2(ConvCycles_g + 2);
  logic [CW-1:0] conv_cnt_q;
  logic          busy_q;

  // Conversion timer: a trigger (re)loads the counter; reaching 0 latches
  // the new temperature and signals ready.
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      conv_cnt_q <= '0;
      busy_q     <= 1'b0;
      temp_q     <= 16'h0000;
      rdy_n_q    <= 1'b1;
    end else begin
      if (rdy_clr) rdy_n_q <= 1'b1;
      if (trig) begin
        busy_q     <= 1'b1;
        conv_cnt_q <= CW'(ConvCycles_g);
      end else if (busy_q) begin
        if (conv_cnt_q == '0) begin
          busy_q  <= 1'b0;
          temp_q  <= Temperature_i;
          rdy_n_q <= 1'b0;
        end else begin
          conv_cnt_q <= conv_cnt_q - CW'(1);
        end
      end
    end
  end

  assign Busy_o = busy_q;
`else
  // Instant conversion: latch the temperature the cycle after the pulse.
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      temp_q  <= 16'h0000;
      rdy_n_q <= 1'b1;
    end else begin
      if (rdy_clr) rdy_n_q <= 1'b1;
      if (oneshot_q) begin
        temp_q  <= Temperature_i;
        rdy_n_q <= 1'b0;
      end
    end
  end

  assign Busy_o = 1'b0;
`endif

  assign MISO_o      = miso_q;
  assign ConfigReg_o = config_q;
  assign TempReg_o   = temp_q;
  assign OneShot_o   = oneshot_q;

endmodule

// File: tb/tb_adt7310_responder.sv
// Directed bench for adt7310_responder: register reads, config writes,
// one-shot conversion timing, aborted transfers and reset mid-byte.
module tb_adt7310_responder;

  localparam int CONV = 300;
`ifdef ADT7310_RESPONDER_CONVDELAY_EN
  localparam int  EXP_LAT     = CONV + 1;
  localparam logic EXP_BUSY   = 1'b1;
  localparam logic [7:0] EXP_ST_EARLY = 8'h80;
`else
  localparam int  EXP_LAT     = 1;
  localparam logic EXP_BUSY   = 1'b0;
  localparam logic [7:0] EXP_ST_EARLY = 8'h00;
`endif

  logic        Clk_i = 1'b0;
  logic        Reset_n_i = 1'b0;
  logic        SCK_i = 1'b1;
  logic        CS_n_i = 1'b1;
  logic        MOSI_i = 1'b0;
  logic        MISO_o;
  logic [15:0] Temperature_i = 16'h0C80;
  logic [7:0]  ConfigReg_o;
  logic [15:0] TempReg_o;
  logic        OneShot_o;
  logic        Busy_o;

  adt7310_responder #(.ConvCycles_g(CONV), .IdValue_g(8'hC3)) dut (
    .Clk_i         (Clk_i),
    .Reset_n_i     (Reset_n_i),
    .SCK_i         (SCK_i),
    .CS_n_i        (CS_n_i),
    .MOSI_i        (MOSI_i),
    .MISO_o        (MISO_o),
    .Temperature_i (Temperature_i),
    .ConfigReg_o   (ConfigReg_o),
    .TempReg_o     (TempReg_o),
    .OneShot_o     (OneShot_o),
    .Busy_o        (Busy_o)
  );

  // Clock.
  always #5 Clk_i = ~Clk_i;

  int total = 0;
  int bad = 0;

  // Monitor: one-shot pulse count and temperature-update latency.
  int          cyc = 0;
  int          pulses = 0;
  int          oneshot_cyc = 0;
  int          temp_cyc = 0;
  logic        temp_seen = 1'b0;
  logic [15:0] temp_prev = 16'h0000;

  always @(negedge Clk_i) begin
    cyc = cyc + 1;
    if (OneShot_o === 1'b1) begin
      pulses = pulses + 1;
      oneshot_cyc = cyc;
    end
    if (TempReg_o !== temp_prev) begin
      temp_cyc = cyc;
      temp_seen = 1'b1;
    end
    temp_prev = TempReg_o;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks: mode 3, each SCK phase 6 Clk cycles.
  task automatic cs_begin();
    @(negedge Clk_i);
    CS_n_i = 1'b0;
    repeat (6) @(negedge Clk_i);
  endtask

  task automatic cs_end();
    repeat (2) @(negedge Clk_i);
    CS_n_i = 1'b1;
    repeat (8) @(negedge Clk_i);
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      @(negedge Clk_i);
      SCK_i  = 1'b0;
      MOSI_i = tx[7-i];
      repeat (6) @(negedge Clk_i);
      SCK_i = 1'b1;
      rx    = {rx[6:0], MISO_o};
      repeat (6) @(negedge Clk_i);
    end
  endtask

  task automatic rd8(input logic [7:0] cmd, output logic [7:0] data);
    logic [7:0] dummy;
    cs_begin();
    xfer(cmd, 8, dummy);
    xfer(8'hFF, 8, data);
    cs_end();
  endtask

  task automatic wr8(input logic [7:0] cmd, input logic [7:0] data);
    logic [7:0] dummy;
    cs_begin();
    xfer(cmd, 8, dummy);
    xfer(data, 8, dummy);
    cs_end();
  endtask

  initial begin
    logic [7:0] b0, b1, b2;
    int         pulses_before;

    // Reset.
    Reset_n_i = 1'b0;
    repeat (5) @(negedge Clk_i);
    check_eq("rst_miso",    32'(MISO_o),      32'h1);
    check_eq("rst_config",  32'(ConfigReg_o), 32'h00);
    check_eq("rst_temp",    32'(TempReg_o),   32'h0000);
    check_eq("rst_busy",    32'(Busy_o),      32'h0);
    check_eq("rst_oneshot", 32'(OneShot_o),   32'h0);
    Reset_n_i = 1'b1;
    repeat (5) @(negedge Clk_i);

    // ID read; MISO is idle-high during the command byte.
    cs_begin();
    xfer(8'h58, 8, b0);
    xfer(8'hFF, 8, b1);
    cs_end();
    check_eq("id_cmd_phase", 32'(b0), 32'hFF);
    check_eq("id_read",      32'(b1), 32'hC3);

    // Status before any conversion: RDY_n = 1.
    rd8(8'h40, b0);
    check_eq("status_initial", 32'(b0), 32'h80);

    // Aborted write: CS rises after 4 data bits.
    cs_begin();
    xfer(8'h08, 8, b0);
    xfer(8'h20, 4, b0);
    cs_end();
    check_eq("abort_config", 32'(ConfigReg_o), 32'h00);
    check_eq("abort_pulses", 32'(pulses),      32'd0);

    // One-shot write.
    temp_seen = 1'b0;
    wr8(8'h08, 8'h20);
    check_eq("wr_config", 32'(ConfigReg_o), 32'h20);
    check_eq("wr_pulses", 32'(pulses),      32'd1);
    check_eq("wr_busy",   32'(Busy_o),      32'(EXP_BUSY));

    // Status sampled at decode, before conversion end when the delay exists.
    rd8(8'h40, b0);
    check_eq("status_early", 32'(b0), 32'(EXP_ST_EARLY));

    // Wait for the temperature update with a bounded budget.
    for (int i = 0; i < 1000 && !temp_seen; i++) @(negedge Clk_i);
    check_eq("conv_done",    32'(temp_seen),             32'h1);
    check_eq("conv_temp",    32'(TempReg_o),             32'h0C80);
    check_eq("conv_latency", 32'(temp_cyc - oneshot_cyc), 32'(EXP_LAT));
    check_eq("conv_busy",    32'(Busy_o),                32'h0);

    rd8(8'h40, b0);
    check_eq("status_ready", 32'(b0), 32'h00);

    // Temperature read, then RDY_n re-arms.
    cs_begin();
    xfer(8'h50, 8, b0);
    xfer(8'hFF, 8, b1);
    xfer(8'hFF, 8, b2);
    cs_end();
    check_eq("temp_read", 32'({b1, b2}), 32'h0C80);
    rd8(8'h40, b0);
    check_eq("status_after_read", 32'(b0), 32'h80);

    // Over-long temperature read: third data byte is all ones.
    cs_begin();
    xfer(8'h50, 8, b0);
    xfer(8'hFF, 8, b0);
    xfer(8'hFF, 8, b1);
    xfer(8'hFF, 8, b2);
    cs_end();
    check_eq("long_b0", 32'(b0), 32'h0C);
    check_eq("long_b1", 32'(b1), 32'h80);
    check_eq("long_b2", 32'(b2), 32'hFF);

    // Non-one-shot config write: no pulse.
    pulses_before = pulses;
    wr8(8'h08, 8'h80);
    check_eq("wr2_config", 32'(ConfigReg_o), 32'h80);
    check_eq("wr2_pulses", 32'(pulses),      32'(pulses_before));

    // Reset in the middle of a temperature data byte (MISO currently 0).
    cs_begin();
    xfer(8'h50, 8, b0);
    xfer(8'hFF, 4, b0);
    check_eq("mid_miso_low", 32'(MISO_o), 32'h0);
    @(negedge Clk_i);
    Reset_n_i = 1'b0;
    #1;
    check_eq("mid_rst_miso",   32'(MISO_o),      32'h1);
    check_eq("mid_rst_config", 32'(ConfigReg_o), 32'h00);
    check_eq("mid_rst_temp",   32'(TempReg_o),   32'h0000);
    CS_n_i = 1'b1;
    repeat (5) @(negedge Clk_i);
    Reset_n_i = 1'b1;
    repeat (5) @(negedge Clk_i);

    rd8(8'h58, b0);
    check_eq("id_after_rst", 32'(b0), 32'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adt7310_responder.md
# adt7310_responder

SPI responder that emulates the register interface of an ADT7310 temperature sensor. It is the far end of the sensor SPI link: it decodes the command byte sent by the ADT7310 application's SPI master and services configuration writes and register reads. Temperature values come from a testbench or stimulus port. The block sits on the chip-external SPI pins of the WSN SoC bench and sensor-emulation FPGA builds. All logic runs on the system clock; SCK is oversampled, not used as a clock.

## Interface
Parameters:
- ConvCycles_g, default 240: Clk_i cycles from a one-shot trigger to the temperature register update.
- IdValue_g, default 8'hC3: value returned by the ID register.

Ports:
- Clk_i  input  1  system clock, rising edge.
- Reset_n_i  input  1  asynchronous, active-low reset.
- SCK_i  input  1  SPI clock from the master, mode 3 (CPOL=1, CPHA=1).
- CS_n_i  input  1  chip select, active low.
- MOSI_i  input  1  serial data from the master, MSB first.
- MISO_o  output  1  serial data to the master. Reset value 1.
- Temperature_i  input  16  next conversion result.
- ConfigReg_o  output  8  config register (addr 1). Reset value 8'h00.
- TempReg_o  output  16  temperature register (addr 2). Reset value 16'h0000.
- OneShot_o  output  1  one-cycle pulse on a one-shot trigger. Reset value 0.
- Busy_o  output  1  conversion in progress. Reset value 0.

## Operation
- SCK_i, CS_n_i and MOSI_i each pass through 2-FF synchronizers. Edges are detected on the synchronized SCK.
- Sampling and shifting:
  - SCK rising edge while CS low: sample MOSI into the shift register.
  - SCK falling edge while CS low: shift the next MISO bit out.
- Command byte, bits 7..0:
  - bit 7: 0.
  - bit 6: R/W, 1 = read.
  - bits 5:3: register address.
  - bit 2: continuous-read flag, ignored.
  - bits 1:0: ignored.
  - Examples: 8'h08 = write config; 8'h50 = read temperature.
- Registers:
  - addr 0: status, 8 bit, read-only. Bit 7 = RDY_n, other bits 0.
  - addr 1: config, 8 bit, R/W.
  - addr 2: temperature, 16 bit, read-only.
  - addr 3: ID, 8 bit, read-only, value IdValue_g.
  - addr 4–7: read 0; writes ignored.
- FSM states and transitions:
  - IDLE → CMD on a CS falling edge.
  - CMD → DATA after 8 sampled bits (command decoded).
  - DATA: read path or write path, below.
  - DONE: absorbs surplus bits.
  - Any state → IDLE when CS goes high.
- Read path: the register is loaded into the transmit shifter (8 or 16 bits) once the command is decoded. The MSB appears on the next SCK falling edge. After the register length, MISO_o = 1 (DONE).
- Write path: the config byte is committed at the 8th data rising edge. It is not committed if CS rises before that edge. Bits after the 8th are ignored.
- A config write with bits 6:5 = 2'b01 (one-shot mode) triggers a conversion:
  - OneShot_o pulses.
  - Busy_o goes high.
  - The conversion counter loads ConvCycles_g.
- Conversion end (counter reaches 0):
  - TempReg_o ← Temperature_i.
  - RDY_n ← 0.
  - Busy_o ← 0.
- Reading addr 2 sets RDY_n ← 1 at CS rise. RDY_n resets to 1.
- A one-shot write during Busy restarts the counter; only one update follows.
- CS rise mid-byte: the partial byte is discarded, MISO_o returns to 1, and no register changes.
- Reset mid-transfer: all outputs go to reset values immediately; the next transaction starts from IDLE.

## Timing
- SCK high and low phases must each last ≥ 4 Clk_i cycles. CS low to first SCK fall must be ≥ 4 Clk_i cycles.
- MISO_o update: ≤ 4 Clk_i cycles after the raw SCK falling edge (2 synchronizer + 1 detect + 1 register).
- Config commit to ConfigReg_o: 1 cycle after the detected 8th data rising edge. OneShot_o pulses in that same cycle.
- TempReg_o update: exactly ConvCycles_g + 1 cycles after OneShot_o.
- A conversion end that coincides with an ongoing temperature read does not corrupt the shift data. The read returns the value latched at command decode.

## Configuration
- `ADT7310_RESPONDER_CONVDELAY_EN` defined: conversion counter present, timing as above.
- Not defined: no counter, Busy_o tied 0. TempReg_o ← Temperature_i in the cycle after OneShot_o, with RDY_n ← 0 at the same time.

## Structure
- Shared package `adt7310_responder_pkg`:
  - FSM state enum (IDLE, CMD, DATA, DONE).
  - Register address constants (ADDR_STATUS=0, ADDR_CONFIG=1, ADDR_TEMP=2, ADDR_ID=3).
  - Mode field constant MODE_ONESHOT=2'b01.
- One sub-module, `spi_slave_sync_edge`: input synchronizers plus SCK rise/fall and CS fall/rise strobes.

## Test plan
- After reset: MISO_o=1, ConfigReg_o=00, TempReg_o=0000, Busy_o=0.
- Read ID: send 8'h58 then 8'hFF → MISO byte 8'hC3.
- Write config and read temperature:
  - Send 8'h08, 8'h20 with Temperature_i=16'h0C80 → ConfigReg_o=20 and OneShot_o pulses once.
  - Temperature updates after ConvCycles_g+1 cycles.
  - Send 8'h50, FFFF → MISO 16'h0C80.
- Status flag: read status (8'h40) before conversion end → 8'h80. After conversion end → 8'h00. After a temperature read → 8'h80.
- Aborted write: send 8'h08, then 4 bits of 8'h20, then CS high → ConfigReg_o unchanged and no OneShot_o pulse.
- Over-long read: send 8'h50 plus 3 dummy bytes → third byte reads 8'hFF. Asserting reset mid-byte returns MISO_o=1 immediately.
